// File: rtl/cache_read_resp.sv
// Read-side responder for the 2-way L1 data cache: returns hit words, or fetches the
// line on a miss (after an optional dirty-victim writeback) and hands it to the arrays.
module cache_read_resp (
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_read,
   input  logic [31:0]  mem_address,
   input  logic         hit1,
   input  logic         hit2,
   input  logic [255:0] data1,
   input  logic [255:0] data2,
   input  logic         lru,
   input  logic         victim_dirty,
   input  logic         wb_done,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp,
   output logic [31:0]  mem_rdata,
   output logic         mem_resp,
   output logic         pmem_read,
   output logic [31:0]  pmem_address,
   output logic         wb_req,
   output logic         fill_we1,
   output logic         fill_we2,
   output logic [255:0] fill_data
);

   typedef enum logic [2:0] {IDLE, CHECK, WRITEBACK, MISS, FILL, RESP} state_t;

   state_t     state;
   logic [2:0] word_q;
   logic       lru_q;
   logic       unused_byte_bits;

   assign unused_byte_bits = ^mem_address[1:0];

   function automatic logic [31:0] pick(input logic [255:0] line, input logic [2:0] sel);
      pick = line[{sel, 5'b0} +: 32];
   endfunction

   // Strobes are registered alongside the state transition so each one
   // tracks exactly the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         word_q       <= '0;
         lru_q        <= 1'b0;
         mem_rdata    <= '0;
         mem_resp     <= 1'b0;
         pmem_read    <= 1'b0;
         pmem_address <= '0;
         wb_req       <= 1'b0;
         fill_we1     <= 1'b0;
         fill_we2     <= 1'b0;
         fill_data    <= '0;
      end else begin
         mem_resp <= 1'b0;
         fill_we1 <= 1'b0;
         fill_we2 <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_read) begin
                  word_q       <= mem_address[4:2];
                  pmem_address <= {mem_address[31:5], 5'b0};
                  state        <= CHECK;
               end
            end
            CHECK: begin
               if (hit1) begin
                  mem_rdata <= pick(data1, word_q);
                  mem_resp  <= 1'b1;
                  state     <= RESP;
               end else if (hit2) begin
                  mem_rdata <= pick(data2, word_q);
                  mem_resp  <= 1'b1;
                  state     <= RESP;
               end else begin
                  lru_q <= lru;
                  if (victim_dirty) begin
                     wb_req <= 1'b1;
                     state  <= WRITEBACK;
                  end else begin
                     pmem_read <= 1'b1;
                     state     <= MISS;
                  end
               end
            end
            WRITEBACK: begin
               if (wb_done) begin
                  wb_req    <= 1'b0;
                  pmem_read <= 1'b1;
                  state     <= MISS;
               end
            end
            MISS: begin
               if (pmem_resp) begin
                  fill_data <= pmem_rdata;
                  mem_rdata <= pick(pmem_rdata, word_q);
                  pmem_read <= 1'b0;
                  fill_we1  <= ~lru_q;
                  fill_we2  <= lru_q;
                  state     <= FILL;
               end
            end
            FILL: begin
               mem_resp <= 1'b1;
               state    <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_read_resp.sv
// Directed bench for cache_read_resp: a per-cycle timeline model of the expected
// strobes and data, checked every cycle, plus literal pins on key results.
module tb_cache_read_resp;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read;
   logic [31:0]  mem_address;
   logic         hit1, hit2;
   logic [255:0] data1, data2;
   logic         lru, victim_dirty, wb_done;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic [31:0]  mem_rdata;
   logic         mem_resp;
   logic         pmem_read;
   logic [31:0]  pmem_address;
   logic         wb_req;
   logic         fill_we1, fill_we2;
   logic [255:0] fill_data;

   cache_read_resp dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_address(mem_address),
      .hit1(hit1), .hit2(hit2), .data1(data1), .data2(data2), .lru(lru),
      .victim_dirty(victim_dirty), .wb_done(wb_done), .pmem_rdata(pmem_rdata),
      .pmem_resp(pmem_resp), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_address(pmem_address), .wb_req(wb_req),
      .fill_we1(fill_we1), .fill_we2(fill_we2), .fill_data(fill_data)
   );

   always #5 clk = ~clk;

   int unsigned chk_n = 0, pass_n = 0;

   // expected outputs for the current cycle, set by the driver after each posedge
   logic         chk_en = 1'b0;
   logic         exp_resp = 0, exp_pread = 0, exp_wb = 0, exp_we1 = 0, exp_we2 = 0, exp_zero = 0;
   logic [31:0]  exp_rdata = '0, exp_paddr = '0;
   logic [255:0] exp_fill = '0;

   // observation record kept by the compare process
   int unsigned  cyc_n = 0, resp_n = 0, pread_n = 0, wb_n = 0, both_n = 0, we1_n = 0, we2_n = 0;
   int unsigned  last_resp_cyc = 0, prev_resp_cyc = 0, presp_cyc = 0;
   logic [31:0]  last_rdata = '0, last_paddr = '0;
   logic [255:0] last_fill = '0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      chk_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   function automatic logic [255:0] mk_line(input logic [31:0] seed);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = seed + i * 32'h0101_0101;
      return l;
   endfunction

   function automatic logic [255:0] put(input logic [255:0] l, input int idx, input logic [31:0] w);
      logic [255:0] r;
      r = l;
      r[idx*32 +: 32] = w;
      return r;
   endfunction

   // addressed word = byte offset within the 32-byte line divided by 4
   function automatic logic [31:0] word_of(input logic [255:0] l, input logic [31:0] a);
      logic [255:0] t;
      t = l >> (32 * ((a % 32) / 4));
      return t[31:0];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         cyc_n++;
         chk("mem_resp", {255'b0, mem_resp}, {255'b0, exp_resp});
         chk("pmem_read", {255'b0, pmem_read}, {255'b0, exp_pread});
         chk("wb_req", {255'b0, wb_req}, {255'b0, exp_wb});
         chk("fill_we1", {255'b0, fill_we1}, {255'b0, exp_we1});
         chk("fill_we2", {255'b0, fill_we2}, {255'b0, exp_we2});
         if (exp_resp) chk("mem_rdata", {224'b0, mem_rdata}, {224'b0, exp_rdata});
         if (exp_pread) chk("pmem_address", {224'b0, pmem_address}, {224'b0, exp_paddr});
         if (exp_we1 || exp_we2) chk("fill_data", fill_data, exp_fill);
         if (exp_zero) begin
            chk("zero_rdata", {224'b0, mem_rdata}, '0);
            chk("zero_paddr", {224'b0, pmem_address}, '0);
            chk("zero_fill", fill_data, '0);
         end
         if (mem_resp) begin
            resp_n++; last_rdata = mem_rdata;
            prev_resp_cyc = last_resp_cyc; last_resp_cyc = cyc_n;
         end
         if (pmem_read) begin pread_n++; last_paddr = pmem_address; end
         if (wb_req) wb_n++;
         if (wb_req && pmem_read) both_n++;
         if (fill_we1) we1_n++;
         if (fill_we2) begin we2_n++; last_fill = fill_data; end
         if (pmem_resp) presp_cyc = cyc_n;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      exp_resp = 0; exp_pread = 0; exp_wb = 0; exp_we1 = 0; exp_we2 = 0;
   endtask

   task automatic idle(input int unsigned n);
      mem_read = 1'b0;
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   // one complete transaction starting in IDLE; expectations follow the cycle rules
   task automatic txn(input logic [31:0] a, input logic h1, input logic h2,
                      input logic [255:0] l1, input logic [255:0] l2, input logic [255:0] pl,
                      input logic lr, input logic dirty, input int unsigned wbn,
                      input int unsigned pd, input logic hold, input logic drop);
      mem_read = 1'b1; mem_address = a;
      tick();
      hit1 = h1; hit2 = h2; data1 = l1; data2 = l2; lru = lr; victim_dirty = dirty;
      if (drop) mem_read = 1'b0;
      tick();
      hit1 = 1'b0; hit2 = 1'b0; lru = ~lr; victim_dirty = ~dirty;
      data1 = ~l1; data2 = ~l2;
      if (h1 || h2) begin
         exp_resp = 1; exp_rdata = word_of(h1 ? l1 : l2, a);
         if (!hold) mem_read = 1'b0;
         tick();
         return;
      end
      if (dirty) begin
         for (int unsigned i = 0; i < wbn; i++) begin
            exp_wb = 1; wb_done = (i == wbn - 1);
            pmem_resp = (i == 0);
            pmem_rdata = ~pl;
            tick();
         end
         wb_done = 1'b0; pmem_resp = 1'b0;
      end
      for (int unsigned i = 0; i <= pd; i++) begin
         exp_pread = 1; exp_paddr = a - (a % 32);
         pmem_resp = (i == pd); pmem_rdata = pl;
         tick();
      end
      pmem_resp = 1'b0; pmem_rdata = '0;
      exp_we1 = ~lr; exp_we2 = lr; exp_fill = pl;
      tick();
      exp_resp = 1; exp_rdata = word_of(pl, a);
      if (!hold) mem_read = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [255:0] la, lb, lp;
      int unsigned  p0, w0, b0, e1, e2;

      rst = 1; mem_read = 0; mem_address = '0; hit1 = 0; hit2 = 0; data1 = '0; data2 = '0;
      lru = 0; victim_dirty = 0; wb_done = 0; pmem_rdata = '0; pmem_resp = 0;
      tick();
      chk_en = 1; exp_zero = 1;
      tick();
      rst = 0;
      tick(); tick();
      exp_zero = 0;

      // way1 hit, word 5
      la = put(mk_line(32'h1000_0000), 5, 32'hDEAD_BEEF);
      lb = mk_line(32'h2000_0000);
      p0 = pread_n;
      txn(32'h0000_1014, 1, 0, la, lb, '0, 0, 0, 0, 0, 0, 0);
      chk("hit1_word5", {224'b0, last_rdata}, {224'b0, 32'hDEAD_BEEF});
      chk("hit1_no_pread", p0, pread_n);
      idle(2);

      // both ways hit: way1 wins
      la = put(mk_line(32'h3000_0000), 0, 32'h1111_1111);
      lb = put(mk_line(32'h4000_0000), 0, 32'h2222_2222);
      txn(32'h0000_0040, 1, 1, la, lb, '0, 0, 0, 0, 0, 0, 0);
      chk("double_hit", {224'b0, last_rdata}, {224'b0, 32'h1111_1111});
      idle(1);

      // way2 hit on the top word
      lb = put(mk_line(32'h5000_0000), 7, 32'h7777_ABCD);
      txn(32'h0000_009F, 0, 1, mk_line(32'h6), lb, '0, 0, 0, 0, 0, 0, 0);
      chk("hit2_word7", {224'b0, last_rdata}, {224'b0, 32'h7777_ABCD});
      idle(1);

      // clean miss into way2, memory answers on the 6th MISS cycle
      lp = put(mk_line(32'h0A0B_0C0D), 7, 32'hCAFE_F00D);
      e2 = we2_n; e1 = we1_n;
      txn(32'h0000_203C, 0, 0, la, lb, lp, 1, 0, 0, 5, 0, 0);
      chk("clean_paddr", {224'b0, last_paddr}, {224'b0, 32'h0000_2020});
      chk("clean_rdata", {224'b0, last_rdata}, {224'b0, 32'hCAFE_F00D});
      chk("clean_we2_count", we2_n - e2, 1);
      chk("clean_we1_count", we1_n - e1, 0);
      chk("clean_fill", last_fill, lp);
      chk("clean_resp_lag", last_resp_cyc - presp_cyc, 2);
      idle(1);

      // dirty miss into way1, writeback takes 3 cycles, mem_read dropped early, word 0
      lp = put(mk_line(32'h0F00_0000), 0, 32'h0BAD_CAFE);
      w0 = wb_n; b0 = both_n; e1 = we1_n;
      txn(32'h0000_3000, 0, 0, la, lb, lp, 0, 1, 3, 0, 0, 1);
      chk("dirty_wb_cycles", wb_n - w0, 3);
      chk("dirty_no_overlap", both_n - b0, 0);
      chk("dirty_we1_count", we1_n - e1, 1);
      chk("dirty_rdata", {224'b0, last_rdata}, {224'b0, 32'h0BAD_CAFE});
      idle(1);

      // back-to-back hits with mem_read held high across RESP
      la = put(mk_line(32'h1234_0000), 2, 32'hAAAA_0002);
      lb = put(mk_line(32'h5678_0000), 3, 32'hBBBB_0003);
      txn(32'h0000_0508, 1, 0, la, lb, '0, 0, 0, 0, 0, 1, 0);
      txn(32'h0000_060C, 0, 1, la, lb, '0, 0, 0, 0, 0, 1, 0);
      chk("b2b_spacing", last_resp_cyc - prev_resp_cyc, 3);
      chk("b2b_second_word", {224'b0, last_rdata}, {224'b0, 32'hBBBB_0003});
      idle(2);

      // reset mid-miss: pmem_read drops, no fill or response afterwards
      e1 = we1_n; e2 = we2_n;
      mem_read = 1'b1; mem_address = 32'h0000_4444;
      tick();
      lru = 0; victim_dirty = 0;
      tick();
      exp_pread = 1; exp_paddr = 32'h0000_4440;
      tick();
      exp_pread = 1; exp_paddr = 32'h0000_4440;
      rst = 1;
      tick();
      mem_read = 1'b0; exp_zero = 1;
      tick();
      rst = 0;
      tick();
      tick(); tick(); tick();
      exp_zero = 0;
      chk("abort_no_fill", (we1_n - e1) + (we2_n - e2), 0);
      idle(2);

      chk_en = 0;
      $display("%0d/%0d checks passed", pass_n, chk_n);
      $finish;
   end

endmodule

// File: doc/cache_read_resp.md
# cache_read_resp

Read-side responder for the 2-way L1 data cache: it is the counterpart of the write-hit byte-merge path. It accepts CPU read requests, checks the way-hit results from the data and tag arrays, and returns the addressed 32-bit word from the hitting line. On a miss it requests the 256-bit line from physical memory, hands the line to the arrays for fill (after a dirty-victim writeback handshake), and returns the word from the fetched line.

## Interface
Parameters: none (line 256 bits, word 32 bits, offset 5 bits fixed).

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request; held high by CPU until mem_resp
- mem_address  in  32  CPU byte address; [4:2] word select, [1:0] ignored
- hit1, hit2  in  1  way hit flags for latched index, valid in CHECK
- data1, data2  in  256  way line data for latched index, valid in CHECK
- lru  in  1  victim way (0 = way1, 1 = way2), sampled in CHECK
- victim_dirty  in  1  victim line dirty, sampled in CHECK
- wb_done  in  1  writeback path finished victim eviction (1-cycle pulse)
- pmem_rdata  in  256  line from physical memory, valid with pmem_resp
- pmem_resp  in  1  physical memory read completion (1-cycle pulse)
- mem_rdata  out  32  returned word, valid while mem_resp=1
- mem_resp  out  1  1-cycle response pulse
- pmem_read  out  1  physical memory line read request
- pmem_address  out  32  {latched_addr[31:5], 5'b0}
- wb_req  out  1  request victim writeback
- fill_we1, fill_we2  out  1  1-cycle line write strobe per way
- fill_data  out  256  registered fetched line

## Operation
- States: IDLE, CHECK, WRITEBACK, MISS, FILL, RESP.
- IDLE: when mem_read=1, latch mem_address into addr_q and go to CHECK. Otherwise stay.
- CHECK: if hit1, select data1. Else if hit2, select data2. hit1 has priority when both are set. On a hit, register word [addr_q[4:2]*32 +: 32] into mem_rdata and go to RESP. On a miss, latch lru and go to WRITEBACK if victim_dirty=1, else to MISS.
- WRITEBACK: wb_req=1. Go to MISS on the cycle wb_done=1.
- MISS: pmem_read=1, pmem_address valid. When pmem_resp=1, capture pmem_rdata into fill_data, extract the word into mem_rdata, and go to FILL.
- FILL: assert fill_we1 if lru_q=0, else fill_we2, for exactly 1 cycle. Then go to RESP.
- RESP: mem_resp=1, then go to IDLE. A new request is accepted no earlier than the cycle after RESP.
- mem_read falling mid-transaction is ignored; the transaction completes and mem_resp still pulses.
- pmem_read, wb_req, mem_resp and fill_we* are decoded from state only. They are glitch-free and never asserted together, except that pmem_address is held steady across MISS.
- hit1, hit2, lru and victim_dirty are ignored outside CHECK. pmem_resp is ignored outside MISS, and wb_done outside WRITEBACK.

## Timing
- Reset: state=IDLE. All outputs 0: mem_rdata=0, fill_data=0, pmem_address=0, mem_resp=0, pmem_read=0, wb_req=0, fill_we1=0, fill_we2=0.
- rst in any state returns to IDLE on the next edge. A strobe in flight drops the following cycle. No fill or response is issued for the aborted request.
- Hit: request accepted at cycle 0, CHECK at cycle 1, mem_resp at cycle 2 (latency 2).
- Clean miss: pmem_read from cycle 2 through the pmem_resp cycle N. FILL at N+1, mem_resp at N+2. pmem_read is low at N+1.
- Dirty miss: wb_req from cycle 2 through the wb_done cycle W. pmem_read from W+1.
- pmem_resp in the first MISS cycle is legal: FILL follows on the next cycle.
- Word select covers all 8 positions with no wrap: word 7 = bits [255:224].

## Test plan
- Reset: assert rst for 2 cycles during a miss with pmem_read=1 -> next cycle all outputs 0, state IDLE. No fill_we pulse follows.
- Way1 hit: addr 0x0000_1014, hit1=1, data1 word5=0xDEAD_BEEF -> mem_resp at cycle 2, mem_rdata=0xDEAD_BEEF. No pmem_read.
- Double hit: hit1=hit2=1, data1 word0=0x1111_1111, data2 word0=0x2222_2222, addr 0x40 -> mem_rdata=0x1111_1111.
- Clean miss: addr 0x0000_203C, lru=1, victim_dirty=0, pmem_resp after 5 cycles, word7=0xCAFE_F00D -> pmem_address=0x0000_2020. fill_we2 for 1 cycle with fill_data=pmem_rdata. mem_resp 2 cycles after pmem_resp with 0xCAFE_F00D.
- Dirty miss: victim_dirty=1, wb_done after 3 cycles -> wb_req for exactly 3 cycles, then pmem_read. pmem_read is never high together with wb_req.
- Back-to-back: mem_read held high across RESP -> second request latched in the cycle after RESP. Two mem_resp pulses separated by exactly 3 cycles on hits.
